ntt_bfly_pipe: RTL and testbench

Pipelined Cooley-Tukey butterfly stage for the 14-bit, q = 12289 NTT datapath. It sits directly downstream of the Barrett modular multiplier. Each beat takes coefficient `a` and the reduced product `t = w·b mod q`, and emits `u = (a + t) mod q` and `v = (a − t) mod q`. A valid/ready handshake, beat/stage counters and frame markers let it drive the coefficient RAM write-back.

---
 rtl/ntt_pkg.sv | 25 ++
 rtl/ntt_bfly_pipe_mod_addsub.sv | 28 ++
 rtl/ntt_bfly_pipe.sv | 164 ++++++++++++++++
 tb/tb_ntt_bfly_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, coefficient type and the modular-halving helper
// for the q = 12289 NTT datapath.
//   NTT_V      coefficient width (14)
//   NTT_Q      modulus (12289)
//   NTT_HALF_N butterflies per stage (128)
//   NTT_LOG_N  stages per transform (8)
//   mod_half   x/2 mod Q, used when NTT_BFLY_HALVE_EN is defined
package ntt_pkg;

  localparam int               NTT_V      = 14;
  localparam logic [NTT_V-1:0] NTT_Q      = 14'd12289;
  localparam int               NTT_HALF_N = 128;
  localparam int               NTT_LOG_N  = 8;

  typedef logic [NTT_V-1:0] coef_t;

  // Q is odd, so an odd x becomes even after adding Q; the shift is then an
  // exact division. The V+1-bit intermediate holds x + Q without overflow.
  function automatic coef_t mod_half(input coef_t x);
    logic [NTT_V:0] w_ext;
    w_ext = x[0] ? ({1'b0, x} + {1'b0, NTT_Q}) : {1'b0, x};
    return w_ext[NTT_V:1];
  endfunction

endpackage

// File: rtl/ntt_bfly_pipe_mod_addsub.sv
// mod_addsub: combinational modular add/subtract for one butterfly.
//   i_a, i_t : operands, expected < Q
//   o_u      : (a + t) mod Q
//   o_v      : (a - t) mod Q
// Both paths use a V+1-bit intermediate and a single conditional -Q.
module mod_addsub #(
  parameter int         V = 14,
  parameter logic [V-1:0] Q = 14'd12289
) (
  input  logic [V-1:0] i_a,
  input  logic [V-1:0] i_t,
  output logic [V-1:0] o_u,
  output logic [V-1:0] o_v
);

  logic [V:0] w_q;
  logic [V:0] w_s;
  logic [V:0] w_d;

  assign w_q = {1'b0, Q};
  assign w_s = {1'b0, i_a} + {1'b0, i_t};
  // Adding Q before subtracting keeps d in 1..2Q-1 for legal inputs.
  assign w_d = {1'b0, i_a} + w_q - {1'b0, i_t};

  assign o_u = (w_s >= w_q) ? V'(w_s - w_q) : V'(w_s);
  assign o_v = (w_d >= w_q) ? V'(w_d - w_q) : V'(w_d);

endmodule

// File: rtl/ntt_bfly_pipe.sv
// ntt_bfly_pipe: two-stage pipelined Cooley-Tukey butterfly, u = a + t,
// v = a - t (mod Q), with valid/ready handshake and frame markers.
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    input handshake; in_a, in_t coefficients (< Q)
//   out_valid/out_ready  output handshake; out_u, out_v results
//   out_last             final butterfly of the current stage
//   stage_idx            stage of the current output beat
//   done                 one-cycle pulse after the last beat of the transform
//   range_err            sticky: an accepted input was >= Q
// Optional feature macro NTT_BFLY_HALVE_EN adds input `halve`, which scales
// both outputs by 1/2 mod Q (inverse-NTT scaling) with unchanged latency.
module ntt_bfly_pipe
  import ntt_pkg::*;
#(
  parameter int           V      = NTT_V,
  parameter logic [V-1:0] Q      = NTT_Q,
  parameter int           HALF_N = NTT_HALF_N,
  parameter int           LOG_N  = NTT_LOG_N
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [V-1:0]             in_a,
  input  logic [V-1:0]             in_t,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [V-1:0]             out_u,
  output logic [V-1:0]             out_v,
  output logic                     out_last,
  output logic [$clog2(LOG_N)-1:0] stage_idx,
  output logic                     done,
  output logic                     range_err
`ifdef NTT_BFLY_HALVE_EN
  ,input logic                     halve
`endif
);

  localparam int BW = $clog2(HALF_N);
  localparam int SW = $clog2(LOG_N);

  logic          r_s1_valid;
  logic [V-1:0]  r_s1_a;
  logic [V-1:0]  r_s1_t;
  logic          r_s2_valid;
  logic [V-1:0]  r_u;
  logic [V-1:0]  r_v;
  logic [BW-1:0] r_beat_cnt;
  logic [SW-1:0] r_stage;
  logic          r_done;
  logic          r_range_err;

  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_s2_load;
  logic          w_beat_last;
  logic          w_stage_last;
  logic [V-1:0]  w_u;
  logic [V-1:0]  w_v;
  logic [V-1:0]  w_u_fin;
  logic [V-1:0]  w_v_fin;

  // Ready whenever the pipe has a hole or the output is draining this cycle;
  // whenever this is high, S1's beat is guaranteed to move into S2.
  assign in_ready     = ~r_s1_valid | ~r_s2_valid | out_ready;
  assign w_in_fire    = in_valid & in_ready;
  assign w_out_fire   = r_s2_valid & out_ready;
  assign w_s2_load    = ~r_s2_valid | out_ready;
  assign w_beat_last  = (r_beat_cnt == BW'(HALF_N - 1));
  assign w_stage_last = (r_stage == SW'(LOG_N - 1));

  mod_addsub #(
    .V (V),
    .Q (Q)
  ) u_mod_addsub (
    .i_a (r_s1_a),
    .i_t (r_s1_t),
    .o_u (w_u),
    .o_v (w_v)
  );

`ifdef NTT_BFLY_HALVE_EN
  logic r_s1_halve;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_halve <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_halve <= halve;
    end
  end

  assign w_u_fin = r_s1_halve ? mod_half(w_u) : w_u;
  assign w_v_fin = r_s1_halve ? mod_half(w_v) : w_v;
`else
  assign w_u_fin = w_u;
  assign w_v_fin = w_v;
`endif

  // Pipeline stages. Data registers only load with a real beat so that the
  // output holds steady while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_t     <= '0;
      r_s2_valid <= 1'b0;
      r_u        <= '0;
      r_v        <= '0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_a <= in_a;
          r_s1_t <= in_t;
        end
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_u <= w_u_fin;
          r_v <= w_v_fin;
        end
      end
    end
  end

  // Frame counters advance only on accepted output beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat_cnt  <= '0;
      r_stage     <= '0;
      r_done      <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_out_fire) begin
        if (w_beat_last) begin
          r_beat_cnt <= '0;
          if (w_stage_last) begin
            r_stage <= '0;
            r_done  <= 1'b1;
          end else begin
            r_stage <= r_stage + 1'b1;
          end
        end else begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
      end
      if (w_in_fire && ((in_a >= Q) || (in_t >= Q))) begin
        r_range_err <= 1'b1;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_u     = r_u;
  assign out_v     = r_v;
  assign out_last  = r_s2_valid & w_beat_last;
  assign stage_idx = r_stage;
  assign done      = r_done;
  assign range_err = r_range_err;

endmodule

// File: tb/tb_ntt_bfly_pipe.sv
// Self-checking bench for ntt_bfly_pipe. A queue-based reference model holds
// the expected results of every beat in flight, computed with plain modular
// arithmetic; frame markers follow from the count of accepted output beats.
// Build with +define+NTT_BFLY_HALVE_EN to also exercise the halving option.
module tb_ntt_bfly_pipe;
  import ntt_pkg::*;

  localparam int QI = 12289;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_a;
  logic [13:0] in_t;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_u;
  logic [13:0] out_v;
  logic        out_last;
  logic [2:0]  stage_idx;
  logic        done;
  logic        range_err;
  logic        halve;

  always #5 clk = ~clk;

  ntt_bfly_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_t      (in_t),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_u     (out_u),
    .out_v     (out_v),
    .out_last  (out_last),
    .stage_idx (stage_idx),
    .done      (done),
    .range_err (range_err)
`ifdef NTT_BFLY_HALVE_EN
    ,.halve    (halve)
`endif
  );

  typedef struct {
    int u;
    int v;
    bit chk;
    int rdy;
  } beat_t;

  beat_t q[$];
  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int out_idx  = 0;
  int done_cnt = 0;
  bit exp_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle(input bit iv, input int a, input int t, input bit h,
                       input bit ordy, output bit acc);
    int  eu;
    int  ev;
    bit  rdy_now;
    in_valid  = iv;
    in_a      = a[13:0];
    in_t      = t[13:0];
    halve     = h;
    out_ready = ordy;
    #1;
    chk("done", done, exp_done);
    if (done === 1'b1) done_cnt++;
    exp_done = 0;
    chk("out_valid", out_valid, (q.size() > 0 && q[0].rdy <= cyc));
    chk("in_ready", in_ready, !(q.size() == 2 && !ordy));
    rdy_now = in_ready;
    if (out_valid === 1'b1 && q.size() > 0) begin
      if (q[0].chk) begin
        chk("out_u", out_u, q[0].u);
        chk("out_v", out_v, q[0].v);
      end
      chk("out_last", out_last, (out_idx % 128) == 127);
      chk("stage_idx", stage_idx, (out_idx / 128) % 8);
      if (ordy) begin
        if ((out_idx % 1024) == 1023) exp_done = 1;
        out_idx++;
        void'(q.pop_front());
      end
    end else begin
      chk("out_last_idle", out_last, 0);
    end
    acc = iv && rdy_now;
    if (acc) begin
      eu = (a + t) % QI;
      ev = (a - t + QI) % QI;
`ifdef NTT_BFLY_HALVE_EN
      // Halving is multiplication by the inverse of 2, which is 6145 mod Q.
      if (h) begin
        eu = int'((longint'(eu) * 6145) % QI);
        ev = int'((longint'(ev) * 6145) % QI);
      end
`endif
      q.push_back('{u: eu, v: ev, chk: (a < QI && t < QI), rdy: cyc + 2});
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    out_idx  = 0;
    exp_done = 0;
    cyc++;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_u", out_u, 0);
    chk("rst_out_v", out_v, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_stage_idx", stage_idx, 0);
    chk("rst_done", done, 0);
    chk("rst_range_err", range_err, 0);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 50 && q.size() > 0; i++) cycle(0, 0, 0, 0, 1, acc);
    chk("drain_empty", q.size(), 0);
  endtask

  // Single beat, idle pipe: visible exactly two cycles after acceptance.
  task automatic directed(input int a, input int t, input bit h, input int eu, input int ev);
    bit acc;
    cycle(1, a, t, h, 1, acc);
    chk("dir_accept", acc, 1);
    cycle(0, 0, 0, 0, 1, acc);
    cycle(0, 0, 0, 0, 0, acc);
    #1;
    chk("dir_valid", out_valid, 1);
    chk("dir_u", out_u, eu);
    chk("dir_v", out_v, ev);
    drain();
  endtask

  initial begin
    bit acc;
    int sent;
    int ordy;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_t      = '0;
    halve     = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    do_reset();

    // Basic and wrap-boundary values.
    directed(5, 3, 0, 8, 2);
    directed(3, 5, 0, 8, 12287);
    directed(12288, 12288, 0, 12287, 0);
    directed(0, 0, 0, 0, 0);
    directed(0, 12288, 0, 12288, 1);
`ifdef NTT_BFLY_HALVE_EN
    directed(5, 3, 1, 4, 1);
    directed(1, 0, 1, 6145, 6145);
`endif

    // Back-pressure: random valid and ready.
    sent = 0;
    for (int i = 0; i < 2000 && sent < 10; i++) begin
      ordy = $urandom_range(0, 1);
      cycle(bit'($urandom_range(0, 1)), $urandom_range(0, QI - 1),
            $urandom_range(0, QI - 1), 0, bit'(ordy), acc);
      if (acc) sent++;
    end
    chk("bp_sent", sent, 10);
    drain();

    // Frame markers over a whole transform, starting from a clean count.
    do_reset();
    done_cnt = 0;
    sent = 0;
    for (int i = 0; i < 3000 && sent < 1024; i++) begin
      cycle(1, $urandom_range(0, QI - 1), $urandom_range(0, QI - 1), 0, 1, acc);
      if (acc) sent++;
    end
    chk("frame_sent", sent, 1024);
    drain();
    cycle(0, 0, 0, 0, 1, acc);
    chk("frame_done_cnt", done_cnt, 1);
    chk("frame_stage_wrap", stage_idx, 0);

    // Reset mid-stream with both stages full at beat 50 of a stage.
    for (int i = 0; i < 500 && out_idx < 1074; i++) begin
      cycle(1, $urandom_range(0, QI - 1), $urandom_range(0, QI - 1), 0, 1, acc);
    end
    chk("mid_beat50", out_idx, 1074);
    cycle(1, 7, 9, 0, 0, acc);
    cycle(1, 7, 9, 0, 0, acc);
    chk("mid_full", q.size(), 2);
    do_reset();
    sent = 0;
    for (int i = 0; i < 500 && sent < 128; i++) begin
      cycle(1, $urandom_range(0, QI - 1), $urandom_range(0, QI - 1), 0, 1, acc);
      if (acc) sent++;
    end
    drain();
    chk("mid_restart_stage", stage_idx, 1);

    // Sticky range error.
    chk("range_clear", range_err, 0);
    cycle(1, 12289, 0, 0, 1, acc);
    drain();
    chk("range_set", range_err, 1);
    directed(100, 200, 0, 300, 12189);
    chk("range_hold", range_err, 1);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
